// File: rtl/dmem_pkg.sv
// Shared encodings and the request-legality helper for the data memory unit.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when the size is reserved or the address is not naturally aligned.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return (offset != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response port of the data memory unit; the MEM stage is the master.
interface data_mem_unit_if #(
    parameter int ADDR_WIDTH = 11
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

endinterface

// File: rtl/dmem_bank.sv
// Four byte-lane RAMs sharing one word index; lane 0 holds the byte at offset 0.
module dmem_bank #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic [3:0]            i_we,
    input  logic [ADDR_WIDTH-3:0] i_idx,
    input  logic [3:0][7:0]       i_wdata,
    output logic [3:0][7:0]       o_rdata
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_rd;

        // NOTE: storage has no reset branch so it maps onto block RAM; contents are undefined until written.
        always_ff @(posedge clock) begin
            if (i_we[k]) begin
                r_mem[i_idx] <= i_wdata[k];
            end
            r_rd <= r_mem[i_idx];
        end

        assign o_rdata[k] = r_rd;
    end

endmodule

// File: rtl/data_mem_unit.sv
// Byte/half/word data memory with alignment checking, sign extension and
// programmable wait states behind a valid/ready request port.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int WAIT_STATES = 0
) (
    input  logic            clock,
    input  logic            reset,
    data_mem_unit_if.slave  bus
);

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_error;

    logic                  w_accept;
    logic                  w_idle;
    logic                  w_commit;
    logic                  w_write;
    logic [1:0]            w_size;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_wdata;
    logic [1:0]            w_off;
    logic [3:0]            w_lane_we;
    logic [3:0]            w_bank_we;
    logic [3:0][7:0]       w_lane_wdata;
    logic [3:0][7:0]       w_bank_rdata;
    logic                  w_rsp_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;

    assign w_idle          = (r_state == IDLE);
    assign bus.req_ready   = w_idle && !reset;
    assign bus.busy        = !w_idle;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_error   = r_rsp_error;
    assign w_accept        = bus.req_valid && bus.req_ready;

    // With no wait states the acceptance edge is also the commit edge, so the live request drives the bank.
    assign w_write = w_idle ? bus.req_write : r_write;
    assign w_size  = w_idle ? bus.req_size  : r_size;
    assign w_addr  = w_idle ? bus.req_addr  : r_addr;
    assign w_wdata = w_idle ? bus.req_wdata : r_wdata;
    assign w_off   = w_addr[1:0];

    assign w_commit = (w_accept && (WAIT_STATES == 0)) ||
                      ((r_state == WAIT) && (r_cnt == 4'd0) && !reset);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        w_lane_we    = 4'b0000;
        w_lane_wdata = '0;
        case (w_size)
            SZ_BYTE: begin
                w_lane_we[w_off]    = 1'b1;
                w_lane_wdata[w_off] = w_wdata[7:0];
            end
            SZ_HALF: begin
                w_lane_we[w_off]            = 1'b1;
                w_lane_we[w_off + 2'd1]     = 1'b1;
                w_lane_wdata[w_off]         = w_wdata[15:8];
                w_lane_wdata[w_off + 2'd1]  = w_wdata[7:0];
            end
            SZ_WORD: begin
                w_lane_we = 4'b1111;
                for (int k = 0; k < 4; k++) begin
                    w_lane_wdata[k] = w_wdata[31-8*k -: 8];
                end
            end
            default: w_lane_we = 4'b0000;
        endcase
    end

    assign w_bank_we = (w_commit && w_write && !access_error(w_size, w_off)) ? w_lane_we : 4'b0000;

    dmem_bank #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clock   (clock),
        .i_we    (w_bank_we),
        .i_idx   (w_addr[ADDR_WIDTH-1:2]),
        .i_wdata (w_lane_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Big-endian assembly from the bank read issued on the commit edge.
    assign w_rsp_err = access_error(r_size, r_addr[1:0]);
    assign w_byte    = w_bank_rdata[r_addr[1:0]];
    assign w_half    = {w_bank_rdata[r_addr[1:0]], w_bank_rdata[r_addr[1:0] + 2'd1]};

    always_comb begin
        case (r_size)
            SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = {w_bank_rdata[0], w_bank_rdata[1], w_bank_rdata[2], w_bank_rdata[3]};
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write  <= bus.req_write;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_cnt    <= WAIT_LOAD;
                        r_state  <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= w_rsp_err;
                    r_rsp_rdata <= (r_write || w_rsp_err) ? 32'd0 : w_load_data;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
